// File: rtl/demux1_n_buf.sv
// demux1_n_buf
//   Routes each accepted payload to one of N output ports. Every port has its
//   own 2-entry FIFO, so a stalled consumer only blocks traffic that is headed
//   for its own port. A payload whose selector is out of range is accepted,
//   dropped, and flagged with a one-cycle err pulse.
//
// Parameters
//   LENGTH   payload width in bits
//   N        number of output ports (1..16)
//   SEL_BITS selector width
//
// Ports
//   clk        rising-edge clock for all state
//   rst        asynchronous, active-high reset
//   in_valid   producer offers in_data this cycle
//   in_ready   block accepts the offered payload this cycle
//   in_sel     destination port index of the offered payload
//   in_data    offered payload
//   out_valid  bit i: port i holds at least one payload
//   out_ready  bit i: consumer i takes the head payload this cycle
//   out_data   head payload of each port, packed [port][bit]
//   err        one-cycle pulse after an out-of-range in_sel was accepted
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. valid may not wait for ready; ready here depends only on in_sel and
// stored FIFO occupancy, never on out_ready, so there is no pass-through path.
module demux1_n_buf #(
  parameter int LENGTH   = 1,
  parameter int N        = 2,
  parameter int SEL_BITS = (N > 1) ? $clog2(N) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [SEL_BITS-1:0]          in_sel,
  input  logic [LENGTH-1:0]            in_data,
  output logic [N-1:0]                 out_valid,
  input  logic [N-1:0]                 out_ready,
  output logic [N-1:0][LENGTH-1:0]     out_data,
  output logic                         err
);

  // Per-port FIFO: head is the oldest entry and drives out_data directly,
  // tail only holds the second entry when count is 2.
  logic [N-1:0][1:0]        count_q;
  logic [N-1:0][LENGTH-1:0] head_q;
  logic [N-1:0][LENGTH-1:0] tail_q;

  logic [N-1:0] hit;      // one-hot decode of in_sel (all zero when out of range)
  logic         sel_bad;  // in_sel names no port
  logic [N-1:0] push;
  logic [N-1:0] pop;

  always_comb begin
    hit     = '0;
    sel_bad = 1'b0;
    if (N == 1) begin
      // Single port: the selector is ignored entirely.
      hit[0] = 1'b1;
    end else begin
      sel_bad = (32'(in_sel) >= 32'(N));
      for (int i = 0; i < N; i++) begin
        hit[i] = (32'(in_sel) == 32'(i));
      end
    end
  end

  // Ready defaults high so an out-of-range selector is always accepted (and
  // dropped); a real port only refuses when its FIFO is full.
  always_comb begin
    in_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (hit[i] && (count_q[i] == 2'd2)) in_ready = 1'b0;
    end
  end

  always_comb begin
    push      = '0;
    pop       = '0;
    out_valid = '0;
    for (int i = 0; i < N; i++) begin
      out_valid[i] = (count_q[i] != 2'd0);
      push[i]      = in_valid && in_ready && hit[i];
      pop[i]       = out_ready[i] && (count_q[i] != 2'd0);
    end
  end

  assign out_data = head_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      err     <= 1'b0;
    end else begin
      // in_ready is always 1 for a bad selector, so valid alone means accepted.
      err <= in_valid && sel_bad;
      for (int i = 0; i < N; i++) begin
        case (count_q[i])
          2'd0: begin
            if (push[i]) begin
              head_q[i]  <= in_data;
              count_q[i] <= 2'd1;
            end
          end
          2'd1: begin
            if (push[i] && pop[i]) begin
              // Head leaves and the new payload takes its place.
              head_q[i] <= in_data;
            end else if (push[i]) begin
              tail_q[i]  <= in_data;
              count_q[i] <= 2'd2;
            end else if (pop[i]) begin
              count_q[i] <= 2'd0;
            end
          end
          default: begin
            // Full: push is impossible because in_ready is low for this port.
            if (pop[i]) begin
              head_q[i]  <= tail_q[i];
              count_q[i] <= 2'd1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_demux1_n_buf.sv
// tb_demux1_n_buf
//   Directed checks on a 4-port instance and randomized traffic on a 3-port
//   instance (whose 2-bit selector can name a non-existent port 3), compared
//   against a queue-per-port reference model.
module tb_demux1_n_buf;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- 4-port instance ----------------
  logic            a_in_valid;
  logic            a_in_ready;
  logic [1:0]      a_in_sel;
  logic [7:0]      a_in_data;
  logic [3:0]      a_out_valid;
  logic [3:0]      a_out_ready;
  logic [3:0][7:0] a_out_data;
  logic            a_err;

  demux1_n_buf #(.LENGTH(8), .N(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_sel    (a_in_sel),
    .in_data   (a_in_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .err       (a_err)
  );

  // ---------------- 3-port instance ----------------
  logic            b_in_valid;
  logic            b_in_ready;
  logic [1:0]      b_in_sel;
  logic [7:0]      b_in_data;
  logic [2:0]      b_out_valid;
  logic [2:0]      b_out_ready;
  logic [2:0][7:0] b_out_data;
  logic            b_err;

  demux1_n_buf #(.LENGTH(8), .N(3)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_sel    (b_in_sel),
    .in_data   (b_in_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .err       (b_err)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q [3][$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(input logic v, input logic [1:0] s, input logic [7:0] d);
    a_in_valid = v;
    a_in_sel   = s;
    a_in_data  = d;
  endtask

  task automatic a_push(input logic [1:0] s, input logic [7:0] d);
    a_drive(1'b1, s, d);
    cyc();
    a_drive(1'b0, 2'd0, 8'h00);
  endtask

  // ---------------- main sequence ----------------
  int         bad_sent;
  int         err_seen;
  logic       exp_err;
  logic       exp_ready;
  logic [2:0] exp_valid;

  initial begin
    rst         = 1'b1;
    a_in_valid  = 1'b1;  // offered during reset; must not be taken
    a_in_sel    = 2'd1;
    a_in_data   = 8'hEE;
    a_out_ready = 4'b0000;
    b_in_valid  = 1'b0;
    b_in_sel    = 2'd0;
    b_in_data   = 8'h00;
    b_out_ready = 3'b000;

    // Reset state, with an offer pending across a clock edge.
    #3;
    check("rst_out_valid", 32'(a_out_valid), 32'h0);
    check("rst_out_data", 32'(a_out_data), 32'h0);
    check("rst_err", 32'(a_err), 32'h0);
    check("rst_in_ready", 32'(a_in_ready), 32'h1);
    cyc();
    check("rst_no_transfer", 32'(a_out_valid), 32'h0);
    a_drive(1'b0, 2'd0, 8'h00);
    rst = 1'b0;
    cyc();

    // Single push reaches its port one cycle later.
    a_drive(1'b1, 2'd2, 8'hA1);
    check("a1_in_ready", 32'(a_in_ready), 32'h1);
    cyc();
    a_drive(1'b0, 2'd0, 8'h00);
    check("a1_out_valid", 32'(a_out_valid), 32'b0100);
    check("a1_out_data2", 32'(a_out_data[2]), 32'hA1);
    a_out_ready = 4'b0100;
    cyc();
    a_out_ready = 4'b0000;
    check("a1_drained", 32'(a_out_valid), 32'h0);

    // Fill port 1, stall a third push, then drain in order.
    a_push(2'd1, 8'h11);
    a_push(2'd1, 8'h22);
    a_drive(1'b1, 2'd0, 8'h33);
    #1 check("full_other_port_ready", 32'(a_in_ready), 32'h1);
    a_drive(1'b1, 2'd1, 8'h33);
    #1 check("full_ready_low", 32'(a_in_ready), 32'h0);
    cyc();
    check("stall_head", 32'(a_out_data[1]), 32'h11);
    check("stall_valid", 32'(a_out_valid), 32'b0010);
    a_out_ready = 4'b0010;
    #1 check("no_passthrough", 32'(a_in_ready), 32'h0);
    cyc();
    check("pop_11_head", 32'(a_out_data[1]), 32'h22);
    check("pop_11_ready", 32'(a_in_ready), 32'h1);
    cyc();  // pop 0x22 and push 0x33 on the same edge
    a_drive(1'b0, 2'd0, 8'h00);
    check("order_33_head", 32'(a_out_data[1]), 32'h33);
    check("order_33_valid", 32'(a_out_valid), 32'b0010);
    cyc();
    a_out_ready = 4'b0000;
    check("port1_empty", 32'(a_out_valid), 32'h0);

    // Simultaneous push and pop at count 1 keeps one entry.
    a_push(2'd3, 8'h55);
    check("p3_head55", 32'(a_out_data[3]), 32'h55);
    a_out_ready = 4'b1000;
    a_drive(1'b1, 2'd3, 8'h66);
    #1 check("p3_ready", 32'(a_in_ready), 32'h1);
    cyc();
    a_drive(1'b0, 2'd0, 8'h00);
    a_out_ready = 4'b0000;
    check("p3_valid", 32'(a_out_valid), 32'b1000);
    check("p3_head66", 32'(a_out_data[3]), 32'h66);
    a_out_ready = 4'b1000;
    cyc();
    a_out_ready = 4'b0000;
    check("p3_empty", 32'(a_out_valid), 32'h0);
    check("a_err_quiet", 32'(a_err), 32'h0);

    // Out-of-range selector on the 3-port instance.
    b_in_valid = 1'b1;
    b_in_sel   = 2'd3;
    b_in_data  = 8'h77;
    #1 check("bad_in_ready", 32'(b_in_ready), 32'h1);
    cyc();
    b_in_valid = 1'b0;
    check("bad_err_pulse", 32'(b_err), 32'h1);
    check("bad_out_valid", 32'(b_out_valid), 32'h0);
    cyc();
    check("bad_err_clear", 32'(b_err), 32'h0);

    // Asynchronous reset between edges with ports 0 and 2 full.
    a_push(2'd0, 8'h01);
    a_push(2'd0, 8'h02);
    a_push(2'd2, 8'h03);
    a_push(2'd2, 8'h04);
    check("full_02_valid", 32'(a_out_valid), 32'b0101);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(a_out_valid), 32'h0);
    check("async_rst_data", 32'(a_out_data), 32'h0);
    #1 rst = 1'b0;
    a_drive(1'b1, 2'd0, 8'h99);
    #1 check("post_rst_ready", 32'(a_in_ready), 32'h1);
    cyc();
    a_drive(1'b0, 2'd0, 8'h00);
    check("post_rst_valid", 32'(a_out_valid), 32'b0001);
    check("post_rst_data0", 32'(a_out_data[0]), 32'h99);

    // Randomized traffic on the 3-port instance versus per-port queues.
    bad_sent = 0;
    err_seen = 0;
    exp_err  = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      b_in_valid  = 1'($urandom_range(0, 1));
      b_in_sel    = 2'($urandom_range(0, 3));
      b_in_data   = 8'($urandom);
      b_out_ready = 3'($urandom_range(0, 7));
      #1;
      exp_ready = (b_in_sel == 2'd3) || (exp_q[b_in_sel].size() < 2);
      for (int p = 0; p < 3; p++) exp_valid[p] = (exp_q[p].size() != 0);
      check("rnd_in_ready", 32'(b_in_ready), 32'(exp_ready));
      check("rnd_out_valid", 32'(b_out_valid), 32'(exp_valid));
      check("rnd_err", 32'(b_err), 32'(exp_err));
      if (b_err) err_seen++;
      for (int p = 0; p < 3; p++) begin
        if (exp_q[p].size() != 0) check("rnd_out_data", 32'(b_out_data[p]), 32'(exp_q[p][0]));
      end
      // Model the coming edge: pops first, then the push.
      for (int p = 0; p < 3; p++) begin
        if (b_out_ready[p] && exp_q[p].size() != 0) void'(exp_q[p].pop_front());
      end
      exp_err = b_in_valid && (b_in_sel == 2'd3);
      if (exp_err) bad_sent++;
      if (b_in_valid && exp_ready && b_in_sel != 2'd3) exp_q[b_in_sel].push_back(b_in_data);
    end
    @(negedge clk);
    b_in_valid  = 1'b0;
    b_out_ready = 3'b000;
    #1;
    if (b_err) err_seen++;
    check("rnd_err_count", 32'(err_seen), 32'(bad_sent));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
